conv1d_seq_ctrl: RTL and testbench



---
 rtl/conv1d_pkg.sv | 19 +
 rtl/conv1d_out_fifo.sv | 54 +++++
 rtl/conv1d_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_conv1d_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared constants and state encoding for the 3-tap 1D convolution frame sequencer.
package conv1d_pkg;

  localparam int unsigned SAMPLE_W     = 8;
  localparam int unsigned ACC_W        = 16;
  localparam int unsigned PRE_PAD      = 1;
  localparam int unsigned POST_PUSH    = 2;
  localparam int unsigned FILL_DISCARD = 3;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    STREAM,
    TAIL,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/conv1d_out_fifo.sv
// Small synchronous result FIFO with occupancy count.
// The head entry is read combinationally from storage.
module conv1d_out_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 16,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_ok, rd_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_ok     = rd_en_i && (count_q != '0);
  assign wr_ok     = wr_en_i && ((count_q != CNT_W'(DEPTH)) || rd_ok);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv1d_seq_ctrl.sv
// Frame sequencer: pads a frame of N samples into the 3-tap engine (1 zero ahead, 2 behind),
// drops the pipeline-fill results and returns N results on a valid/ready stream.
module conv1d_seq_ctrl #(
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned SAMPLE_W  = conv1d_pkg::SAMPLE_W,
  parameter int unsigned ACC_W     = conv1d_pkg::ACC_W,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    frame_len,
  output logic                busy,
  output logic                done,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [SAMPLE_W-1:0] eng_data_in,
  output logic                eng_data_valid,
  input  logic [ACC_W-1:0]    eng_data_out,
  input  logic                eng_out_valid,
  output logic [ACC_W-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  import conv1d_pkg::*;

  localparam int unsigned K_W   = LEN_W + 2;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 2;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    n_q, n_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [LEN_W-1:0]    r_q, r_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                eng_valid_q;
  logic [SAMPLE_W-1:0] eng_data_q;
  logic                tag_q, pipe_q;

  logic                push;
  logic [SAMPLE_W-1:0] push_data;
  logic                keep_next, credit_ok, push_ok, pop;
  logic [OCC_W-1:0]    occ;

  logic                fifo_wr, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [ACC_W-1:0]    fifo_head;

  conv1d_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (ACC_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifo_wr),
    .wr_data_i (eng_data_out),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // pipe_q tracks the keep tag one cycle behind the push, in step with eng_out_valid
  assign fifo_wr = eng_out_valid && pipe_q;
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_head : '0;
  assign m_last  = m_valid && (r_q == n_q - LEN_W'(1));

  // Kept results not yet popped must fit the FIFO, counting one already leaving this cycle
  assign occ       = OCC_W'(fifo_count) + OCC_W'(tag_q) + OCC_W'(pipe_q);
  assign credit_ok = occ < (OCC_W'(OUT_DEPTH) + OCC_W'(pop));
  assign keep_next = k_q >= K_W'(FILL_DISCARD);
  assign push_ok   = !keep_next || credit_ok;

  assign busy           = busy_q;
  assign done           = done_q;
  assign eng_data_valid = eng_valid_q;
  assign eng_data_in    = eng_data_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    r_d       = r_q;
    push      = 1'b0;
    push_data = '0;
    s_ready   = 1'b0;

    if (pop) r_d = r_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            n_d     = frame_len;
            k_d     = '0;
            r_d     = '0;
            state_d = HEAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      HEAD: begin
        push    = 1'b1;
        k_d     = k_q + K_W'(1);
        state_d = STREAM;
      end
      STREAM: begin
        s_ready = push_ok;
        if (s_valid && push_ok) begin
          push      = 1'b1;
          push_data = s_data;
          k_d       = k_q + K_W'(1);
          if (k_q == K_W'(n_q) + K_W'(PRE_PAD) - K_W'(1)) state_d = TAIL;
        end
      end
      TAIL: begin
        if (push_ok) begin
          push = 1'b1;
          k_d  = k_q + K_W'(1);
          if (k_q == K_W'(n_q) + K_W'(POST_PUSH)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!eng_valid_q && !pipe_q && fifo_empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == HEAD) || (state_d == STREAM) || (state_d == TAIL) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      k_q         <= '0;
      r_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eng_valid_q <= 1'b0;
      eng_data_q  <= '0;
      tag_q       <= 1'b0;
      pipe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eng_valid_q <= push;
      eng_data_q  <= push_data;
      tag_q       <= push && keep_next;
      pipe_q      <= tag_q;
    end
  end

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Directed bench: sequencer driving a behavioural 3-tap (1,2,1) engine.
module tb_conv1d_seq_ctrl;
  import conv1d_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] frame_len;
  logic        busy, done;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic [7:0]  eng_data_in;
  logic        eng_data_valid;
  logic [15:0] eng_data_out;
  logic        eng_out_valid;
  logic [15:0] m_data;
  logic        m_valid, m_ready, m_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] res_q[$];
  logic        last_q[$];
  int          push_cnt, done_cnt, max_cnt;
  bit          stall_seen;

  always #5 clk = ~clk;

  conv1d_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .eng_data_in(eng_data_in), .eng_data_valid(eng_data_valid),
    .eng_data_out(eng_data_out), .eng_out_valid(eng_out_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  // Engine: result of a push uses the three previous pushes, weights 1,2,1
  logic [7:0] x0, x1, x2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0 <= '0; x1 <= '0; x2 <= '0;
      eng_data_out <= '0; eng_out_valid <= 1'b0;
    end else begin
      eng_out_valid <= eng_data_valid;
      if (eng_data_valid) begin
        eng_data_out <= {8'd0, x0} + {7'd0, x1, 1'b0} + {8'd0, x2};
        x0 <= eng_data_in; x1 <= x0; x2 <= x1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        res_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      if (eng_data_valid) push_cnt++;
      if (done) done_cnt++;
      if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
      if (s_valid && !s_ready && dut.state_q == STREAM) stall_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    res_q.delete(); last_q.delete();
    push_cnt = 0; done_cnt = 0; max_cnt = 0; stall_seen = 1'b0;
  endtask

  task automatic start_cmd(input int len);
    @(posedge clk); #1;
    start = 1'b1; frame_len = 12'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int smp[8], input bit gaps);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      s_valid = 1'b1; s_data = 8'(smp[i]);
      @(negedge clk);
      while (!s_ready && b < 200) begin @(negedge clk); b++; end
      if (b >= 200) check("feed_timeout", 32'(b), 32'(0));
      @(posedge clk); #1;
      if (gaps) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int b;
    b = 0;
    do begin @(negedge clk); b++; end while (!done && b < 500);
    check({tag, "_done_seen"}, 32'(done), 32'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_results(input string tag, input int n, input int exp[8]);
    check({tag, "_count"}, 32'(res_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      logic        l;
      d = (i < res_q.size()) ? res_q[i] : 16'hxxxx;
      l = (i < last_q.size()) ? last_q[i] : 1'bx;
      check($sformatf("%s_data%0d", tag, i), 32'(d), 32'(exp[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(l), 32'(i == n - 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_eng_in"}, 32'(eng_data_in), 0);
    check({tag, "_eng_valid"}, 32'(eng_data_valid), 0);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_m_data"}, 32'(m_data), 0);
    check({tag, "_m_last"}, 32'(m_last), 0);
  endtask

  initial begin
    int s_a[8], s_b[8], s_c[8], s_d[8];
    int e_a[8], e_b[8], e_c[8], e_d[8];
    int b;
    s_a = '{10, 20, 30, 40, 0, 0, 0, 0};  e_a = '{40, 80, 120, 110, 0, 0, 0, 0};
    s_b = '{5, 5, 5, 0, 0, 0, 0, 0};      e_b = '{15, 20, 15, 0, 0, 0, 0, 0};
    s_c = '{1, 2, 3, 4, 5, 6, 0, 0};      e_c = '{4, 8, 12, 16, 20, 17, 0, 0};
    s_d = '{1, 1, 0, 0, 0, 0, 0, 0};      e_d = '{3, 3, 0, 0, 0, 0, 0, 0};

    reset = 1'b1; start = 1'b0; frame_len = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    // basic frame
    clear_mon();
    start_cmd(4);
    check("basic_busy", 32'(busy), 1);
    feed(4, s_a, 1'b0);
    wait_done("basic");
    check_results("basic", 4, e_a);
    check("basic_pushes", 32'(push_cnt), 7);
    check("basic_done_pulses", 32'(done_cnt), 1);
    check("basic_busy_after", 32'(busy), 0);

    // back-to-back frame, no residue from the previous one
    clear_mon();
    start_cmd(3);
    feed(3, s_b, 1'b0);
    wait_done("b2b");
    check_results("b2b", 3, e_b);
    check("b2b_pushes", 32'(push_cnt), 6);

    // consumer backpressure mid-frame
    clear_mon();
    fork
      begin start_cmd(4); feed(4, s_a, 1'b0); end
      begin repeat (4) @(posedge clk); #1 m_ready = 1'b0;
            repeat (10) @(posedge clk); #1 m_ready = 1'b1; end
    join
    wait_done("bp");
    check_results("bp", 4, e_a);
    check("bp_fifo_max", 32'(max_cnt <= 2), 1);
    check("bp_pushes", 32'(push_cnt), 7);

    // longer frame so credit stalls the upstream stream
    clear_mon();
    m_ready = 1'b0;
    fork
      begin start_cmd(6); feed(6, s_c, 1'b0); end
      begin repeat (14) @(posedge clk); #1 m_ready = 1'b1; end
    join
    wait_done("bp6");
    check_results("bp6", 6, e_c);
    check("bp6_s_ready_stall", 32'(stall_seen), 1);
    check("bp6_fifo_max", 32'(max_cnt <= 2), 1);

    // upstream gaps
    clear_mon();
    start_cmd(4);
    feed(4, s_a, 1'b1);
    wait_done("gaps");
    check_results("gaps", 4, e_a);
    check("gaps_pushes", 32'(push_cnt), 7);

    // zero-length command
    clear_mon();
    start_cmd(0);
    @(negedge clk);
    check("zero_done", 32'(done), 1);
    repeat (4) @(negedge clk);
    check("zero_pushes", 32'(push_cnt), 0);
    check("zero_results", 32'(res_q.size()), 0);
    check("zero_done_pulses", 32'(done_cnt), 1);

    // start while busy is ignored
    clear_mon();
    fork
      begin start_cmd(3); feed(3, s_b, 1'b0); end
      begin repeat (3) @(posedge clk); #1 start = 1'b1; frame_len = 12'd1;
            @(posedge clk); #1 start = 1'b0; end
    join
    wait_done("ign");
    check_results("ign", 3, e_b);
    check("ign_pushes", 32'(push_cnt), 6);
    check("ign_done_pulses", 32'(done_cnt), 1);

    // reset mid-frame after two results
    clear_mon();
    start_cmd(4);
    feed(4, s_a, 1'b0);
    b = 0;
    while (res_q.size() < 2 && b < 100) begin @(negedge clk); b++; end
    check("rst_two_results", 32'(res_q.size() >= 2), 1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    @(negedge clk);
    check("rst_no_done", 32'(done_cnt), 0);
    @(posedge clk); #1 reset = 1'b0;
    clear_mon();
    start_cmd(2);
    feed(2, s_d, 1'b0);
    wait_done("post_rst");
    check_results("post_rst", 2, e_d);
    check("post_rst_pushes", 32'(push_cnt), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
